mul_shift_add: RTL

//  Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.

---
 rtl/mul_shift_add.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mul_shift_add.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU with valid/ready handshakes.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips the iteration and completes one cycle after accept.
module mul_shift_add #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state;
  logic [CNT_W-1:0]        counter;
  logic                    last_iter;

  logic [DATA_WIDTH-1:0]   a_mag;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   plier;
  logic                    neg;
  logic                    hi_sel;

  logic                    sign_a;
  logic                    sign_b;
  logic                    accept;
  logic [DATA_WIDTH:0]     sum;
  logic [2*DATA_WIDTH-1:0] prod;

  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v,
                                                      input logic is_signed);
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    return (is_signed && v[DATA_WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [2*DATA_WIDTH-1:0] apply_sign(input logic [2*DATA_WIDTH-1:0] mag,
                                                         input logic negate);
    return negate ? -mag : mag;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] select_half(input logic [2*DATA_WIDTH-1:0] p,
                                                        input logic upper);
    return upper ? p[2*DATA_WIDTH-1:DATA_WIDTH] : p[DATA_WIDTH-1:0];
  endfunction

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid & in_ready;
  assign sign_a   = multiplicand[DATA_WIDTH-1] & (op != 2'b11);
  assign sign_b   = multiplier[DATA_WIDTH-1] & (op == 2'b01);
  assign sum      = plier[0] ? ({1'b0, acc} + {1'b0, a_mag}) : {1'b0, acc};
  assign prod     = apply_sign({acc, plier}, neg);

`ifdef MUL_ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = (multiplicand == '0) || (multiplier == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      counter   <= '0;
      last_iter <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef MUL_ZERO_BYPASS_EN
            if (zero_op) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= '0;
            end else begin
              state     <= S_CALC;
              counter   <= '0;
              last_iter <= 1'b0;
            end
`else
            state     <= S_CALC;
            counter   <= '0;
            last_iter <= 1'b0;
`endif
          end
        end
        S_CALC: begin
          // The cycle after the final iteration folds in the sign and registers the chosen half.
          if (last_iter) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= select_half(prod, hi_sel);
            last_iter <= 1'b0;
          end else begin
            counter <= (counter == CNT_LAST) ? '0 : counter + 1'b1;
            if (counter == CNT_LAST) begin
              last_iter <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: operand capture on accept, one shift-add step per CALC iteration.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_mag  <= magnitude(multiplicand, op != 2'b11);
      plier  <= magnitude(multiplier, op == 2'b01);
      acc    <= '0;
      neg    <= sign_a ^ sign_b;
      hi_sel <= (op != 2'b00);
    end else if ((state == S_CALC) && !last_iter) begin
      acc   <= sum[DATA_WIDTH:1];
      plier <= {sum[0], plier[DATA_WIDTH-1:1]};
    end
  end

endmodule
